pipeline_run_controller: RTL and testbench

Sequencing controller for the 4-stage 8-bit pipelined core. It does three jobs:
- Loads the 256x17 program memory from an external loader stream while the core is held in reset.
- Runs, halts and single/multi-steps the core through a clock-enable.
- Implements one PC breakpoint plus a 16-bit executed-cycle counter.

It sits between the debug/host command interface and the core's reset, enable and program-memory write port.

---
 rtl/pipeline_run_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_pipeline_run_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
//
// Sequencing controller for the 4-stage 8-bit pipelined core. It loads the
// program memory from an external loader stream while the core is held in
// reset. It runs, halts and single/multi-steps the core through a clock
// enable. It also provides one PC breakpoint and a saturating executed-cycle
// counter.
//
// Ports:
//   clock, reset          system clock, asynchronous active-low reset
//   cmd_valid/ready/op/arg host command channel
//                         (NOP, RUN, HALT, STEP, LOAD, SET_BP, CLR_BP)
//   load_valid/ready/data/last
//                         loader word stream, accepted only in LOAD
//   pm_we/addr/wdata      program memory write port
//   pc                    core program counter (address of next fetch)
//   core_rst_n            registered active-low core reset
//   core_en               combinational core clock enable
//   state                 0 IDLE, 1 LOAD, 2 RUN, 3 STEP, 4 HALT
//   bp_hit, cmd_err       one-cycle status pulses
//   cycle_count           number of core_en cycles, saturating
module pipeline_run_controller #(
    parameter int PC_W  = 8,
    parameter int IW    = 17,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [PC_W-1:0]  cmd_arg,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [IW-1:0]    load_data,
    input  logic             load_last,
    output logic             pm_we,
    output logic [PC_W-1:0]  pm_addr,
    output logic [IW-1:0]    pm_wdata,
    input  logic [PC_W-1:0]  pc,
    output logic             core_rst_n,
    output logic             core_en,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic             cmd_err,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    state_t            state_q;
    state_t            state_n;
    logic              bp_en;
    logic              bp_armed;
    logic [PC_W-1:0]   bp_addr;
    logic [PC_W-1:0]   load_ptr;
    logic [PC_W-1:0]   step_cnt;

    logic              cmd_fire;
    logic              load_fire;
    logic              bp_match;
    logic              bp_set;
    logic              bp_clr;
    logic              hit_n;
    logic              illegal_n;
    logic              clr_count;
    logic              step_load;
    logic              ptr_load;
    logic              disarm;

    assign state      = state_q;
    assign cmd_ready  = (state_q != S_LOAD);
    assign load_ready = (state_q == S_LOAD);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign load_fire  = load_valid && load_ready;

    // Program memory write is a straight pass-through of the accepted word.
    assign pm_we    = load_fire;
    assign pm_addr  = load_ptr;
    assign pm_wdata = load_data;

    // The breakpoint blocks the enable in the cycle the PC points at it,
    // so the core freezes before fetching bp_addr.
    assign bp_match = bp_en && bp_armed && (pc == bp_addr);
    assign core_en  = ((state_q == S_RUN) ||
                       ((state_q == S_STEP) && (step_cnt != '0))) && !bp_match;

    assign bp_set = cmd_fire && (cmd_op == OP_SET_BP);
    assign bp_clr = cmd_fire && (cmd_op == OP_CLR_BP);

    // Next-state and side-effect decode. Breakpoint stops take effect even
    // when a command arrives in the same cycle; a coincident HALT is legal.
    always_comb begin
        state_n   = state_q;
        hit_n     = 1'b0;
        illegal_n = 1'b0;
        clr_count = 1'b0;
        step_load = 1'b0;
        ptr_load  = 1'b0;
        disarm    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN:  begin state_n = S_RUN;  clr_count = 1'b1; end
                        OP_STEP: begin
                            state_n   = S_STEP;
                            clr_count = 1'b1;
                            step_load = 1'b1;
                        end
                        OP_LOAD: begin
                            state_n   = S_LOAD;
                            clr_count = 1'b1;
                            ptr_load  = 1'b1;
                        end
                        OP_RSVD: illegal_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (load_fire && load_last) state_n = S_IDLE;
            end
            S_RUN: begin
                if (bp_match) begin
                    state_n = S_HALT;
                    hit_n   = 1'b1;
                end
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_HALT: state_n = S_HALT;
                        OP_RUN, OP_STEP, OP_LOAD, OP_RSVD: illegal_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_STEP: begin
                if (bp_match) begin
                    state_n = S_HALT;
                    hit_n   = 1'b1;
                end else if (core_en && (step_cnt == PC_W'(1))) begin
                    state_n = S_HALT;
                end
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_HALT: state_n = S_HALT;
                        OP_RUN, OP_STEP, OP_LOAD, OP_RSVD: illegal_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                if (cmd_fire) begin
                    case (cmd_op)
                        OP_RUN: begin
                            state_n = S_RUN;
                            disarm  = (pc == bp_addr);
                        end
                        OP_STEP: begin
                            state_n   = S_STEP;
                            step_load = 1'b1;
                            disarm    = (pc == bp_addr);
                        end
                        OP_LOAD: begin
                            state_n   = S_LOAD;
                            clr_count = 1'b1;
                            ptr_load  = 1'b1;
                        end
                        OP_RSVD: illegal_n = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // FSM state, registered outputs and bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            core_rst_n  <= 1'b0;
            bp_hit      <= 1'b0;
            cmd_err     <= 1'b0;
            cycle_count <= '0;
            bp_en       <= 1'b0;
            bp_addr     <= '0;
            bp_armed    <= 1'b1;
            load_ptr    <= '0;
            step_cnt    <= '0;
        end else begin
            state_q    <= state_n;
            core_rst_n <= !((state_n == S_IDLE) || (state_n == S_LOAD));
            bp_hit     <= hit_n;
            cmd_err    <= illegal_n;

            if (ptr_load)
                load_ptr <= cmd_arg;
            else if (load_fire)
                load_ptr <= load_ptr + PC_W'(1);

            // A step count of zero still executes one instruction.
            if (step_load)
                step_cnt <= (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
            else if (core_en && (state_q == S_STEP))
                step_cnt <= step_cnt - PC_W'(1);

            if (clr_count)
                cycle_count <= '0;
            else if (core_en && (cycle_count != '1))
                cycle_count <= cycle_count + CNT_W'(1);

            if (bp_set) begin
                bp_addr <= cmd_arg;
                bp_en   <= 1'b1;
            end else if (bp_clr) begin
                bp_en   <= 1'b0;
            end

            // Resuming while parked on the breakpoint passes it once; the
            // breakpoint re-arms as soon as the PC moves off it.
            if (bp_set)
                bp_armed <= 1'b1;
            else if (disarm)
                bp_armed <= 1'b0;
            else if (pc != bp_addr)
                bp_armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller
//
// Scoreboard bench for pipeline_run_controller. Stimulus pushes expected
// program-memory writes, breakpoint stops and command errors into a queue;
// a negedge monitor pops and compares whenever the DUT presents one. A small
// core model advances pc on every core_en cycle and clears it in reset.
// Cycle-count expectations come from counting observed core_en cycles since
// the last clearing command, saturated at 0xFFFF.
module tb_pipeline_run_controller;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_HALT   = 3'd2;
    localparam logic [2:0] OP_STEP   = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5;
    localparam logic [2:0] OP_CLR_BP = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_STEP = 3'd3;
    localparam logic [2:0] S_HALT = 3'd4;

    localparam int EV_WR  = 0;
    localparam int EV_BP  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        load_valid;
    logic        load_ready;
    logic [16:0] load_data;
    logic        load_last;
    logic        pm_we;
    logic [7:0]  pm_addr;
    logic [16:0] pm_wdata;
    logic [7:0]  pc = 8'd0;
    logic        core_rst_n;
    logic        core_en;
    logic [2:0]  state;
    logic        bp_hit;
    logic        cmd_err;
    logic [15:0] cycle_count;

    int   checks     = 0;
    int   passed     = 0;
    int   en_cycles  = 0;
    int   clear_base = 0;
    ev_t  exp_q[$];

    pipeline_run_controller dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .pm_we       (pm_we),
        .pm_addr     (pm_addr),
        .pm_wdata    (pm_wdata),
        .pc          (pc),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .state       (state),
        .bp_hit      (bp_hit),
        .cmd_err     (cmd_err),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    // Core model: the PC advances on each enabled cycle, zero while in reset.
    always @(posedge clock) begin
        if (!core_rst_n)
            pc <= 8'd0;
        else if (core_en)
            pc <= pc + 8'd1;
    end

    function automatic longint sat16(input longint v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic matchEvent(input int kind, input string name, input int a, input int b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("[TB] FAIL %s: unexpected event a=0x%0h b=0x%0h, nothing expected",
                     name, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.a == a && e.b == b)
                passed++;
            else
                $display("[TB] FAIL %s: got kind %0d a=0x%0h b=0x%0h, expected kind %0d a=0x%0h b=0x%0h",
                         name, kind, a, b, e.kind, e.a, e.b);
        end
    endtask

    // Monitor: every DUT-presented event is matched against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (pm_we)   matchEvent(EV_WR,  "pm write", int'(pm_addr), int'(pm_wdata));
            if (bp_hit)  matchEvent(EV_BP,  "bp hit",   int'(pc), int'(cycle_count));
            if (cmd_err) matchEvent(EV_ERR, "cmd err",  int'(state), 0);
            if (core_en) en_cycles++;
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] arg);
        @(posedge clock); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_arg   = 8'd0;
    endtask

    task automatic waitState(input logic [2:0] target, input int budget, input string name);
        int n = 0;
        while (state != target && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        @(negedge clock); #1;
        checkOutput(name, state, target);
    endtask

    task automatic loadWord(input logic [7:0] addr, input logic [16:0] data,
                            input bit last, input int gap);
        repeat (gap) begin @(posedge clock); #1; end
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        exp_q.push_back('{EV_WR, int'(addr), int'(data)});
        checkOutput("core_rst_n held low in LOAD", core_rst_n, 0);
        @(posedge clock); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic loadBurst(input logic [7:0] start, input int n);
        clear_base = en_cycles;
        applyStimulus(OP_LOAD, start);
        checkOutput("state LOAD", state, S_LOAD);
        checkOutput("load_ready in LOAD", load_ready, 1);
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = start + 8'(i);
            loadWord(a, 17'($urandom_range(0, 131071)), (i == n - 1), $urandom_range(0, 2));
        end
        @(negedge clock); #1;
        checkOutput("state IDLE after load", state, S_IDLE);
        checkOutput("core_rst_n after load", core_rst_n, 0);
        checkOutput("cycle_count cleared by load", cycle_count, 0);
        checkOutput("load writes drained", exp_q.size(), 0);
    endtask

    task automatic bpRun(input logic [7:0] bp);
        int base;
        clear_base = en_cycles;
        base       = en_cycles;
        applyStimulus(OP_SET_BP, bp);
        exp_q.push_back('{EV_BP, int'(bp), int'(bp)});
        applyStimulus(OP_RUN, 8'd0);
        waitState(S_HALT, 400, "halt on breakpoint");
        checkOutput("run core_en cycles to bp", en_cycles - base, bp);
        checkOutput("pc frozen at bp", pc, bp);
        checkOutput("core_en low at bp", core_en, 0);
        checkOutput("bp event drained", exp_q.size(), 0);
    endtask

    task automatic stepRun(input logic [7:0] n);
        int         base  = en_cycles;
        int         steps = (n == 0) ? 1 : int'(n);
        logic [7:0] pc0   = pc;
        applyStimulus(OP_STEP, n);
        waitState(S_HALT, 300, "step ends in HALT");
        checkOutput("step core_en cycles", en_cycles - base, steps);
        checkOutput("pc after step", pc, (int'(pc0) + steps) & 255);
        checkOutput("cycle_count after step", cycle_count, sat16(en_cycles - clear_base));
    endtask

    initial begin
        logic [2:0] bad_ops[4];
        logic [7:0] bp;
        int         n;
        bad_ops    = '{OP_RUN, OP_STEP, OP_LOAD, OP_RSVD};
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = OP_NOP;
        cmd_arg    = 8'd0;
        load_valid = 1'b0;
        load_data  = 17'd0;
        load_last  = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset state", state, S_IDLE);
        checkOutput("reset core_rst_n", core_rst_n, 0);
        checkOutput("reset core_en", core_en, 0);
        checkOutput("reset bp_hit", bp_hit, 0);
        checkOutput("reset cmd_err", cmd_err, 0);
        checkOutput("reset cycle_count", cycle_count, 0);
        checkOutput("reset pm_we", pm_we, 0);
        checkOutput("reset cmd_ready", cmd_ready, 1);
        @(posedge clock); #3 reset = 1'b1;

        // Fixed load of three words at 0x10.
        clear_base = en_cycles;
        applyStimulus(OP_LOAD, 8'h10);
        checkOutput("cmd_ready low in LOAD", cmd_ready, 0);
        loadWord(8'h10, 17'h1AAAA, 1'b0, 0);
        loadWord(8'h11, 17'h00001, 1'b0, 0);
        loadWord(8'h12, 17'h15555, 1'b1, 0);
        @(negedge clock); #1;
        checkOutput("state IDLE after fixed load", state, S_IDLE);
        checkOutput("fixed load drained", exp_q.size(), 0);

        // Pointer wrap 0xFF -> 0x00.
        applyStimulus(OP_LOAD, 8'hFF);
        loadWord(8'hFF, 17'h0ABCD, 1'b0, 1);
        loadWord(8'h00, 17'h1F00F, 1'b1, 0);
        @(negedge clock); #1;
        checkOutput("state IDLE after wrap load", state, S_IDLE);
        checkOutput("wrap load drained", exp_q.size(), 0);

        for (int i = 0; i < 3; i++)
            loadBurst(8'($urandom_range(0, 255)), $urandom_range(1, 6));

        // Breakpoint at 5, then step across it.
        bpRun(8'h05);
        checkOutput("cycle_count at bp", cycle_count, 5);
        stepRun(8'd3);
        checkOutput("pc after stepping past bp", pc, 8);
        checkOutput("cycle_count after step 3", cycle_count, 8);
        stepRun(8'd0);
        for (int i = 0; i < 3; i++)
            stepRun(8'($urandom_range(0, 6)));

        // Illegal command during STEP.
        n = en_cycles;
        exp_q.push_back('{EV_ERR, int'(S_STEP), 0});
        applyStimulus(OP_STEP, 8'd20);
        applyStimulus(OP_RUN, 8'd0);
        waitState(S_HALT, 300, "long step ends in HALT");
        checkOutput("long step core_en cycles", en_cycles - n, 20);
        checkOutput("step err drained", exp_q.size(), 0);

        // Illegal commands during RUN keep running.
        applyStimulus(OP_RUN, 8'd0);
        for (int i = 0; i < 4; i++) begin
            logic [2:0] op;
            op = bad_ops[$urandom_range(0, 3)];
            exp_q.push_back('{EV_ERR, int'(S_RUN), 0});
            applyStimulus(op, 8'($urandom_range(0, 255)));
            @(negedge clock); #1;
            checkOutput("state stays RUN on illegal cmd", state, S_RUN);
        end
        applyStimulus(OP_HALT, 8'd0);
        @(negedge clock); #1;
        checkOutput("HALT cmd stops run", state, S_HALT);
        checkOutput("run errors drained", exp_q.size(), 0);
        checkOutput("cycle_count after run", cycle_count, sat16(en_cycles - clear_base));

        // Reserved op in HALT.
        exp_q.push_back('{EV_ERR, int'(S_HALT), 0});
        applyStimulus(OP_RSVD, 8'd0);
        @(negedge clock); #1;
        checkOutput("reserved op drained", exp_q.size(), 0);

        // Simultaneous HALT command and breakpoint match.
        loadBurst(8'($urandom_range(0, 255)), 1);
        bp = 8'($urandom_range(3, 30));
        clear_base = en_cycles;
        applyStimulus(OP_SET_BP, bp);
        applyStimulus(OP_RUN, 8'd0);
        n = 0;
        while (pc != bp && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        exp_q.push_back('{EV_BP, int'(bp), int'(bp)});
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        @(negedge clock); #1;
        checkOutput("HALT+bp state", state, S_HALT);
        checkOutput("HALT+bp drained", exp_q.size(), 0);

        // STEP from IDLE cut short by the breakpoint.
        loadBurst(8'h80, 2);
        clear_base = en_cycles;
        n = en_cycles;
        applyStimulus(OP_SET_BP, 8'd4);
        exp_q.push_back('{EV_BP, 4, 4});
        applyStimulus(OP_STEP, 8'd10);
        waitState(S_HALT, 100, "step halted by bp");
        checkOutput("step-to-bp core_en cycles", en_cycles - n, 4);
        checkOutput("step bp drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a run.
        applyStimulus(OP_CLR_BP, 8'd0);
        applyStimulus(OP_RUN, 8'd0);
        repeat (7) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid-run reset state", state, S_IDLE);
        checkOutput("mid-run reset core_rst_n", core_rst_n, 0);
        checkOutput("mid-run reset core_en", core_en, 0);
        checkOutput("mid-run reset cycle_count", cycle_count, 0);
        @(posedge clock); #3 reset = 1'b1;

        // Asynchronous reset in the middle of a load.
        applyStimulus(OP_LOAD, 8'h40);
        loadWord(8'h40, 17'h12345, 1'b0, 0);
        load_valid = 1'b1;
        load_data  = 17'h0F0F0;
        #1;
        checkOutput("pm_we before mid-load reset", pm_we, 1);
        reset = 1'b0;
        #1;
        checkOutput("pm_we forced low by reset", pm_we, 0);
        checkOutput("mid-load reset state", state, S_IDLE);
        checkOutput("mid-load reset load_ready", load_ready, 0);
        load_valid = 1'b0;
        @(posedge clock); #3 reset = 1'b1;
        checkOutput("mid-load writes drained", exp_q.size(), 0);

        // Counter saturation over a long run.
        clear_base = en_cycles;
        applyStimulus(OP_RUN, 8'd0);
        repeat (70000) @(posedge clock);
        #1;
        checkOutput("cycle_count saturated", cycle_count, sat16(en_cycles - clear_base));
        checkOutput("cycle_count at ceiling", cycle_count, 16'hFFFF);
        applyStimulus(OP_HALT, 8'd0);
        @(negedge clock); #1;
        checkOutput("state HALT after long run", state, S_HALT);
        checkOutput("cycle_count held after halt", cycle_count, 16'hFFFF);
        checkOutput("scoreboard empty at end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
